// File: rtl/rvvi_retire_emitter.sv
// Retire-trace producer: stamps order numbers on hart retirements, buffers them in a FWFT FIFO,
// and streams them out on valid/ready. Optional CSR-write fields are enabled by RVVI_TRACE_CSR_EN.
module rvvi_retire_emitter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int AFULL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trace_en,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [31:0]     ret_insn,
  input  logic            ret_trap,
  input  logic [1:0]      ret_mode,
  input  logic [4:0]      ret_rd,
  input  logic            ret_rd_wen,
  input  logic [XLEN-1:0] ret_rd_data,
`ifdef RVVI_TRACE_CSR_EN
  input  logic            ret_csr_wen,
  input  logic [11:0]     ret_csr_addr,
  input  logic [XLEN-1:0] ret_csr_data,
  output logic            tr_csr_wen,
  output logic [11:0]     tr_csr_addr,
  output logic [XLEN-1:0] tr_csr_data,
`endif
  output logic            tr_valid,
  input  logic            tr_ready,
  output logic [63:0]     tr_order,
  output logic [XLEN-1:0] tr_pc,
  output logic [31:0]     tr_insn,
  output logic            tr_trap,
  output logic [1:0]      tr_mode,
  output logic [4:0]      tr_rd,
  output logic            tr_rd_wen,
  output logic [XLEN-1:0] tr_rd_data,
  output logic            hart_stall,
  output logic            overflow,
  output logic [15:0]     drop_cnt,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] STALL_OCC = (AW+1)'(DEPTH - AFULL);

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
    logic [1:0]      mode;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] rd_data;
`ifdef RVVI_TRACE_CSR_EN
    logic            csr_wen;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
`endif
  } rec_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  rec_t        mem [DEPTH];
  rec_t        wr_rec, rd_rec;
  logic [AW:0] wr_ptr, rd_ptr, count, occ_nxt;
  logic [63:0] order_cnt;
  logic        full, empty, cap, push, pop, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // tr_valid comes only from registered pointers, never from tr_ready
  assign tr_valid = !empty;
  assign pop      = tr_valid && tr_ready;
  assign cap      = (state == RUN) && ret_valid;
  assign push     = cap && (!full || pop);
  assign drop     = cap && full && !pop;
  assign occ_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign busy     = (state != IDLE);

  always_comb begin
    wr_rec         = '0;
    wr_rec.order   = order_cnt;
    wr_rec.pc      = ret_pc;
    wr_rec.insn    = ret_insn;
    wr_rec.trap    = ret_trap;
    wr_rec.mode    = ret_mode;
    wr_rec.rd      = ret_rd;
    wr_rec.rd_wen  = ret_rd_wen;
    wr_rec.rd_data = ret_rd_data;
`ifdef RVVI_TRACE_CSR_EN
    wr_rec.csr_wen  = ret_csr_wen;
    wr_rec.csr_addr = ret_csr_addr;
    wr_rec.csr_data = ret_csr_data;
`endif
  end

  // Fields read as zero while empty so the stream is clean out of reset
  assign rd_rec     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign tr_order   = rd_rec.order;
  assign tr_pc      = rd_rec.pc;
  assign tr_insn    = rd_rec.insn;
  assign tr_trap    = rd_rec.trap;
  assign tr_mode    = rd_rec.mode;
  assign tr_rd      = rd_rec.rd;
  assign tr_rd_wen  = rd_rec.rd_wen;
  assign tr_rd_data = rd_rec.rd_data;
`ifdef RVVI_TRACE_CSR_EN
  assign tr_csr_wen  = rd_rec.csr_wen;
  assign tr_csr_addr = rd_rec.csr_addr;
  assign tr_csr_data = rd_rec.csr_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      order_cnt  <= '0;
      hart_stall <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      hart_stall <= (occ_nxt >= STALL_OCC);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Dropped records still consume an order number so the sampler sees the gap
      if (cap)  order_cnt <= order_cnt + 64'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trace_en) state_nxt = RUN;
      RUN:     if (!trace_en) state_nxt = DRAIN;
      DRAIN:   if (trace_en) state_nxt = RUN;
               else if (empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule
